axil_ipif_reg_bridge: RTL
=========================

# axil_ipif_reg_bridge

AXI4-Lite slave that converts single-beat AXI-Lite transactions into the chip-enable style IPIF register bus used by the SPI core and its sibling peripherals. It is the parametrised successor of the fixed four-register address manager. It adds:
- a configurable register count and byte strobes;
- a full write response channel, with read/write arbitration;
- SLVERR for out-of-range addresses, plus an optional acknowledge timeout.

## Interface
Parameters:
- C_NUM_REG, 4: number of 32-bit registers; legal range 1..16.
- C_TIMEOUT, 16: cycles a CE may stay high without acknowledge. Used only when the timeout feature is compiled in; legal range 2..255.

Ports:
- ACLK  in  1  clock; all logic is on its rising edge.
- ARESETn  in  1  reset; synchronous, active-low.
- AWVALID / AWREADY  in/out  1/1  write-address handshake.
- AWADDR  in  32  byte address; bits [1:0] are ignored.
- WVALID / WREADY  in/out  1/1  write-data handshake.
- WDATA  in  32  write data.
- WSTRB  in  4  byte strobes.
- BVALID / BREADY  out/in  1/1  write-response handshake.
- BRESP  out  2  2'b00 = OKAY, 2'b10 = SLVERR.
- ARVALID / ARREADY  in/out  1/1  read-address handshake.
- ARADDR  in  32  byte address.
- RVALID / RREADY  out/in  1/1  read-data handshake.
- RDATA  out  32  read data.
- RRESP  out  2  read response; same encoding as BRESP.
- bus2ip_clk  out  1  equal to ACLK.
- bus2ip_resetn  out  1  equal to ARESETn.
- bus2ip_data  out  32  latched WDATA.
- bus2ip_be  out  4  latched WSTRB.
- bus2ip_wrce  out  C_NUM_REG  one-hot write chip-enable.
- bus2ip_rdce  out  C_NUM_REG  one-hot read chip-enable.
- ip2bus_data  in  32*C_NUM_REG  register k is read from slice [32k+31:32k].
- ip2bus_wrack  in  1  write acknowledge.
- ip2bus_rdack  in  1  read acknowledge.

## Operation
The bridge runs a single FSM with five states: IDLE, WR_CE, WR_RESP, RD_CE, RD_RESP. Exactly one transaction is in flight at a time.

Register index and range check:
- idx = addr[5:2].
- An address is out-of-range when addr[31:2] >= C_NUM_REG.

Arbitration in IDLE:
- A write request is AWVALID && WVALID together. AW is never accepted without W.
- A read request is ARVALID.
- If both are requested, the grant goes to the type not served last. A 1-bit pointer tracks this and is set to "write served last" at reset, so the first contest goes to the read.

Write path:
- AWREADY and WREADY are combinational: high only in IDLE with a granted write. Both fall in the same cycle.
- On the handshake, WDATA and WSTRB are latched into bus2ip_data and bus2ip_be.
- In range: the FSM goes to WR_CE and bus2ip_wrce[idx] is driven high.
- Out of range: the FSM goes directly to WR_RESP with BRESP = SLVERR. No CE is raised.
- In WR_CE, when ip2bus_wrack = 1 the CE clears and the FSM goes to WR_RESP with BRESP = OKAY.
- In WR_RESP, BVALID is held high until BREADY, then the FSM returns to IDLE.

Read path:
- ARREADY is combinational: high only in IDLE with a granted read.
- In range: the FSM goes to RD_CE and bus2ip_rdce[idx] is driven high.
- Out of range: the FSM goes to RD_RESP with RDATA = 0 and RRESP = SLVERR.
- On ip2bus_rdack, the addressed slice of ip2bus_data is latched into RDATA with RRESP = OKAY.
- In RD_RESP, RVALID is held high until RREADY.

Acknowledge handling:
- Acks arriving outside the matching CE state are ignored.
- An ack in the same cycle the CE first rises is valid.

RDATA, BRESP and RRESP hold their values until the next response is loaded.

## Timing
- Reset clears all outputs to 0 (except bus2ip_clk and bus2ip_resetn, which follow their inputs), sets the FSM to IDLE and resets the arbitration pointer.
- Write, handshake at cycle T:
  - wrce is high from T+1.
  - The earliest wrack is at T+1, giving BVALID at T+2.
  - Minimum write occupancy is 3 cycles, including the B handshake.
- Read: same shape, giving RVALID at T+2 at the earliest.
- Out-of-range access: the response valid rises at T+1.
- No new request is accepted until the response handshake completes. The earliest new handshake is the cycle after BREADY/RREADY is sampled high.
- Reset asserted mid-transaction: all CEs and valids drop at the next edge and the transaction is discarded.

## Configuration
- AXIL_IPIF_TIMEOUT_EN defined:
  - A counter runs during WR_CE and RD_CE.
  - If no ack has arrived after C_TIMEOUT cycles with the CE high, the CE drops and the response is SLVERR (for reads, RDATA = 0).
  - An ack arriving on the final counted cycle wins over the timeout.
- AXIL_IPIF_TIMEOUT_EN undefined: the CE states wait indefinitely and no counter logic is present.

## Test plan
- C_NUM_REG = 4. Write 0xA5A5_0001 to 0x8 with WSTRB = 0xF; wrack after 2 cycles -> wrce = 4'b0100 for 2 cycles, bus2ip_data = 0xA5A5_0001, BVALID with BRESP = 00.
- Read 0xC with ip2bus_data[127:96] = 0xDEAD_BEEF; rdack after 1 cycle -> rdce = 4'b1000, RDATA = 0xDEAD_BEEF, RRESP = 00.
- Write to 0x10 and read from 0x40 -> no CE pulse; BRESP = 10 at T+1; RRESP = 10 with RDATA = 0.
- AR and AW+W asserted together twice in succession -> read served first, then write, then read; AWREADY and WREADY are never split.
- AXIL_IPIF_TIMEOUT_EN defined, C_TIMEOUT = 16, no rdack -> rdce high for exactly 16 cycles, then RRESP = 10 and RDATA = 0. Without the macro, rdce stays high for more than 100 cycles.
- ARESETn pulled low while in WR_CE with BREADY held low -> at the next edge wrce = 0, BVALID = 0, FSM in IDLE; a following write completes normally.

Source files
------------

// File: rtl/axil_ipif_reg_bridge.sv
// axil_ipif_reg_bridge
//   AXI4-Lite slave that turns single-beat AXI-Lite accesses into the
//   chip-enable style IPIF register bus. One transaction in flight at a time.
//
//   Build option: define AXIL_IPIF_TIMEOUT_EN to bound how long a CE may wait
//   for its acknowledge (C_TIMEOUT cycles, then SLVERR). Without it the CE
//   states wait indefinitely.
//
// Ports
//   ACLK, ARESETn        clock, synchronous active-low reset
//   AW*/W*/B*            AXI-Lite write address / data / response channels
//   AR*/R*               AXI-Lite read address / data channels
//   bus2ip_clk/resetn    ACLK / ARESETn passed through
//   bus2ip_data/be       latched WDATA / WSTRB
//   bus2ip_wrce/rdce     one-hot chip enables, one bit per register
//   ip2bus_data          register k read data at [32k+31:32k]
//   ip2bus_wrack/rdack   acknowledges from the register file
module axil_ipif_reg_bridge #(
  parameter int C_NUM_REG = 4,
  parameter int C_TIMEOUT = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [31:0]             AWADDR,
  input  logic                    WVALID,
  output logic                    WREADY,
  input  logic [31:0]             WDATA,
  input  logic [3:0]              WSTRB,
  output logic                    BVALID,
  input  logic                    BREADY,
  output logic [1:0]              BRESP,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  input  logic [31:0]             ARADDR,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic [31:0]             RDATA,
  output logic [1:0]              RRESP,
  output logic                    bus2ip_clk,
  output logic                    bus2ip_resetn,
  output logic [31:0]             bus2ip_data,
  output logic [3:0]              bus2ip_be,
  output logic [C_NUM_REG-1:0]    bus2ip_wrce,
  output logic [C_NUM_REG-1:0]    bus2ip_rdce,
  input  logic [32*C_NUM_REG-1:0] ip2bus_data,
  input  logic                    ip2bus_wrack,
  input  logic                    ip2bus_rdack
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, WR_CE, WR_RESP, RD_CE, RD_RESP} state_t;

  state_t      state;
  logic        last_wr;   // 1: a write was served last, so reads win the next contest
  logic [3:0]  idx_q;
  logic        wr_req, rd_req, gnt_wr, gnt_rd;
  logic        aw_oor, ar_oor;
  logic        to_hit;
  logic [31:0] rd_sel;
  logic        unused_addr_lsbs;

  assign bus2ip_clk    = ACLK;
  assign bus2ip_resetn = ARESETn;

  // Byte offset within a register carries no meaning on this bus.
  assign unused_addr_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};

  assign wr_req = AWVALID && WVALID;
  assign rd_req = ARVALID;
  assign gnt_rd = rd_req && (!wr_req || last_wr);
  assign gnt_wr = wr_req && (!rd_req || !last_wr);

  // AW and W are always accepted together.
  assign AWREADY = ARESETn && (state == IDLE) && gnt_wr;
  assign WREADY  = AWREADY;
  assign ARREADY = ARESETn && (state == IDLE) && gnt_rd;

  assign aw_oor = ({2'b00, AWADDR[31:2]} >= 32'(C_NUM_REG));
  assign ar_oor = ({2'b00, ARADDR[31:2]} >= 32'(C_NUM_REG));

  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < C_NUM_REG; k++)
      if (idx_q == 4'(k)) rd_sel = ip2bus_data[32*k +: 32];
  end

  function automatic logic [C_NUM_REG-1:0] ce_dec(input logic [3:0] i);
    ce_dec = '0;
    for (int k = 0; k < C_NUM_REG; k++) ce_dec[k] = (i == 4'(k));
  endfunction

`ifdef AXIL_IPIF_TIMEOUT_EN
  // Counts CE-high cycles; reads n-1 during the n-th cycle of a CE.
  logic [7:0] to_cnt;
  assign to_hit = (to_cnt == 8'(C_TIMEOUT - 1));

  always_ff @(posedge ACLK) begin
    if (!ARESETn || !((state == WR_CE) || (state == RD_CE))) to_cnt <= '0;
    else                                                     to_cnt <= to_cnt + 8'd1;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state       <= IDLE;
      last_wr     <= 1'b1;
      idx_q       <= '0;
      BVALID      <= 1'b0;
      BRESP       <= RESP_OKAY;
      RVALID      <= 1'b0;
      RDATA       <= '0;
      RRESP       <= RESP_OKAY;
      bus2ip_data <= '0;
      bus2ip_be   <= '0;
      bus2ip_wrce <= '0;
      bus2ip_rdce <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_wr) begin
            last_wr     <= 1'b1;
            idx_q       <= AWADDR[5:2];
            bus2ip_data <= WDATA;
            bus2ip_be   <= WSTRB;
            if (aw_oor) begin
              BVALID <= 1'b1;
              BRESP  <= RESP_SLVERR;
              state  <= WR_RESP;
            end else begin
              bus2ip_wrce <= ce_dec(AWADDR[5:2]);
              state       <= WR_CE;
            end
          end else if (gnt_rd) begin
            last_wr <= 1'b0;
            idx_q   <= ARADDR[5:2];
            if (ar_oor) begin
              RVALID <= 1'b1;
              RDATA  <= '0;
              RRESP  <= RESP_SLVERR;
              state  <= RD_RESP;
            end else begin
              bus2ip_rdce <= ce_dec(ARADDR[5:2]);
              state       <= RD_CE;
            end
          end
        end
        WR_CE: begin
          // An ack on the last counted cycle still beats the timeout.
          if (ip2bus_wrack || to_hit) begin
            bus2ip_wrce <= '0;
            BVALID      <= 1'b1;
            BRESP       <= ip2bus_wrack ? RESP_OKAY : RESP_SLVERR;
            state       <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (BREADY) begin
            BVALID <= 1'b0;
            state  <= IDLE;
          end
        end
        RD_CE: begin
          if (ip2bus_rdack || to_hit) begin
            bus2ip_rdce <= '0;
            RVALID      <= 1'b1;
            RDATA       <= ip2bus_rdack ? rd_sel : 32'd0;
            RRESP       <= ip2bus_rdack ? RESP_OKAY : RESP_SLVERR;
            state       <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (RREADY) begin
            RVALID <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
